cpu_instr_sequencer: RTL and testbench

CPU_INSTR_SEQUENCER -- requirements
Module: cpu_instr_sequencer

---
 rtl/cpu_instr_sequencer.sv | 138 +++++++++++++
 tb/tb_cpu_instr_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instr_sequencer.sv
// Steps a 16-word program memory into a CPU, holding each instruction for HOLD_CYCLES cycles
// with a one-cycle NOP gap between instructions.
module cpu_instr_sequencer #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [11:0] prog_word,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  seq_opcode,
   output logic [3:0]  seq_addr,
   output logic [3:0]  seq_data,
   output logic        seq_we,
   output logic [3:0]  pc,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StIssue,
      StGap,
      StDone
   } state_e;

   localparam logic [3:0]  OpHalt   = 4'hF;
   localparam logic [3:0]  OpStore  = 4'h2;
   localparam logic [3:0]  HoldLoad = 4'(HOLD_CYCLES - 1);
   localparam logic [11:0] HaltWord = 12'hF00;

   state_e      state_q, state_d;
   logic [3:0]  pc_q, pc_d;
   logic [3:0]  hold_q, hold_d;
   logic [11:0] instr_q, instr_d;
   logic [11:0] mem_q [16];
   logic [11:0] fetch_word;
   logic        prog_ok;

   // Program memory only accepts writes while no program is running.
   assign prog_ok    = (state_q == StIdle) || (state_q == StDone);
   assign fetch_word = mem_q[pc_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= HaltWord;
         end
      end else if (prog_we && prog_ok) begin
         mem_q[prog_addr] <= prog_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= 4'd0;
         hold_q  <= 4'd0;
         instr_q <= HaltWord;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      instr_d = instr_q;
      if (abort) begin
         state_d = StIdle;
         pc_d    = 4'd0;
         hold_d  = 4'd0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_d = StFetch;
                  pc_d    = 4'd0;
               end
            end
            StFetch: begin
               instr_d = fetch_word;
               if (fetch_word[11:8] == OpHalt) begin
                  state_d = StDone;
               end else begin
                  state_d = StIssue;
                  hold_d  = HoldLoad;
               end
            end
            StIssue: begin
               if (hold_q == 4'd0) begin
                  state_d = StGap;
               end else begin
                  hold_d = hold_q - 4'd1;
               end
            end
            StGap: begin
               // The last slot ends the program rather than wrapping back to 0.
               if (pc_q == 4'd15) begin
                  state_d = StDone;
               end else begin
                  pc_d    = pc_q + 4'd1;
                  state_d = StFetch;
               end
            end
            default: begin
               state_d = StIdle;
               pc_d    = 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      seq_opcode = OpHalt;
      seq_addr   = 4'd0;
      seq_data   = 4'd0;
      seq_we     = 1'b0;
      if (state_q == StIssue) begin
         seq_opcode = instr_q[11:8];
         seq_addr   = instr_q[7:4];
         seq_data   = instr_q[3:0];
         seq_we     = (instr_q[11:8] == OpStore);
      end
   end

   assign pc   = pc_q;
   assign busy = (state_q == StFetch) || (state_q == StIssue) || (state_q == StGap);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Randomised scoreboard bench: a program-level model expands each run into an expected
// per-cycle output trace, and a monitor compares the DUT against it every cycle.
module tb_cpu_instr_sequencer;

   localparam int unsigned H = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = 4'd0;
   logic [11:0] prog_word = 12'd0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  seq_opcode, seq_addr, seq_data, pc;
   logic        seq_we, busy, done;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] addr;
      logic [3:0] data;
      logic       we;
      logic [3:0] pc;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        trace [$];
   exp_t        rest;
   logic [11:0] mem_m [16];
   bit          last_busy;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   cpu_instr_sequencer #(.HOLD_CYCLES(H)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_word  (prog_word),
      .start      (start),
      .abort      (abort),
      .seq_opcode (seq_opcode),
      .seq_addr   (seq_addr),
      .seq_data   (seq_data),
      .seq_we     (seq_we),
      .pc         (pc),
      .busy       (busy),
      .done       (done)
   );

   function automatic exp_t mk(logic [3:0] op, logic [3:0] a, logic [3:0] d, logic w,
                               logic [3:0] p, logic b, logic dn);
      exp_t e;
      e.op = op; e.addr = a; e.data = d; e.we = w; e.pc = p; e.busy = b; e.done = dn;
      return e;
   endfunction

   // Expand the stored program into the cycle-by-cycle output sequence of one run.
   function automatic void build_trace();
      logic [11:0] w;
      trace.delete();
      for (int p = 0; p < 16; p++) begin
         w = mem_m[p];
         trace.push_back(mk(4'hF, 4'd0, 4'd0, 1'b0, 4'(p), 1'b1, 1'b0));
         if (w[11:8] == 4'hF) begin
            rest = mk(4'hF, 4'd0, 4'd0, 1'b0, 4'(p), 1'b0, 1'b1);
            return;
         end
         for (int k = 0; k < H; k++)
            trace.push_back(mk(w[11:8], w[7:4], w[3:0], w[11:8] == 4'h2, 4'(p), 1'b1, 1'b0));
         trace.push_back(mk(4'hF, 4'd0, 4'd0, 1'b0, 4'(p), 1'b1, 1'b0));
         if (p == 15) rest = mk(4'hF, 4'd0, 4'd0, 1'b0, 4'd15, 1'b0, 1'b1);
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mem_m[i] = 12'hF00;
      trace.delete();
      exp_q.delete();
      rest      = mk(4'hF, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      last_busy = 1'b0;
   endtask

   // Drive one cycle of inputs and queue the output expected after the next rising edge.
   task automatic drive_push(input bit st, input bit ab, input bit we, input logic [3:0] a,
                             input logic [11:0] w);
      exp_t e;
      start = st; abort = ab; prog_we = we; prog_addr = a; prog_word = w;
      if (!last_busy && we) mem_m[a] = w;
      if (ab) begin
         trace.delete();
         rest = mk(4'hF, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
         e    = rest;
      end else if (last_busy) begin
         e = (trace.size() != 0) ? trace.pop_front() : rest;
      end else if (st) begin
         build_trace();
         e = trace.pop_front();
      end else begin
         e = rest;
      end
      last_busy = e.busy;
      exp_q.push_back(e);
   endtask

   task automatic step(input bit st, input bit ab, input bit we, input logic [3:0] a,
                       input logic [11:0] w);
      drive_push(st, ab, we, a, w);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
   endtask

   task automatic run_done();
      int n;
      n = 0;
      while (last_busy && n < 300) begin
         idle(1);
         n++;
      end
      checks++;
      if (last_busy) begin
         errors++;
         $display("FAIL run_timeout: still busy after %0d cycles, required idle", n);
      end
      idle(1);
   endtask

   task automatic check_nop(input string name);
      checks++;
      if ({seq_opcode, seq_addr, seq_data, seq_we, pc, busy, done} !== 19'h7800_0 >> 0 &&
          {seq_opcode, seq_addr, seq_data, seq_we, pc, busy, done} !== {4'hF, 15'd0}) begin
         errors++;
         $display("FAIL %s: got op=%h a=%h d=%h we=%b pc=%h busy=%b done=%b, required NOP/pc0/idle",
                  name, seq_opcode, seq_addr, seq_data, seq_we, pc, busy, done);
      end
   endtask

   // Monitor: compare every post-edge cycle while out of reset.
   initial begin
      exp_t e, act;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (rst_n) begin
            act = {seq_opcode, seq_addr, seq_data, seq_we, pc, busy, done};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL no_expectation: cycle %0d got %h, required a queued entry", cyc, act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL cycle_out @%0d: got op=%h a=%h d=%h we=%b pc=%h busy=%b done=%b, required op=%h a=%h d=%h we=%b pc=%h busy=%b done=%b",
                           cyc, act.op, act.addr, act.data, act.we, act.pc, act.busy, act.done,
                           e.op, e.addr, e.data, e.we, e.pc, e.busy, e.done);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0]  op;
      logic [11:0] w;
      model_reset();
      repeat (2) @(negedge clk);
      check_nop("reset_outputs");
      rst_n = 1'b1;
      idle(3);

      // Empty memory: one FETCH then DONE at pc 0.
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      run_done();

      // Short program.
      step(1'b0, 1'b0, 1'b1, 4'd0, 12'h350);
      step(1'b0, 1'b0, 1'b1, 4'd1, 12'h007);
      step(1'b0, 1'b0, 1'b1, 4'd2, 12'hF00);
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      run_done();

      // STORE drives write-enable for the whole hold window.
      step(1'b0, 1'b0, 1'b1, 4'd0, 12'h290);
      step(1'b0, 1'b0, 1'b1, 4'd1, 12'hF00);
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      run_done();

      // Abort in the second ISSUE cycle of instruction 1, then restart.
      step(1'b0, 1'b0, 1'b1, 4'd0, 12'h350);
      step(1'b0, 1'b0, 1'b1, 4'd1, 12'h007);
      step(1'b0, 1'b0, 1'b1, 4'd2, 12'hA23);
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      idle(8);
      step(1'b1, 1'b1, 1'b0, 4'd0, 12'd0);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);

      // Writes and start pulses while busy are ignored.
      idle(3);
      step(1'b0, 1'b0, 1'b1, 4'd3, 12'h101);
      step(1'b1, 1'b0, 1'b1, 4'd3, 12'h101);
      idle(4);
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      run_done();

      // All sixteen slots occupied: ends at pc 15 with no wrap.
      for (int i = 0; i < 16; i++) begin
         op = 4'($urandom_range(0, 14));
         w  = {op, 8'($urandom)};
         step(1'b0, 1'b0, 1'b1, 4'(i), w);
      end
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      run_done();

      // Write and start in the same cycle: the new word at address 0 is fetched.
      step(1'b1, 1'b0, 1'b1, 4'd0, 12'hF00);
      run_done();
      step(1'b1, 1'b0, 1'b1, 4'd0, 12'h4AB);
      run_done();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         w  = {op, 8'($urandom)};
         step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 2) == 0, 4'($urandom), w);
      end
      run_done();

      // Asynchronous reset in the middle of a STORE.
      step(1'b0, 1'b0, 1'b1, 4'd0, 12'h2C0);
      step(1'b0, 1'b0, 1'b1, 4'd1, 12'hF00);
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      idle(1);
      drive_push(1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_nop("async_reset");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      // Memory was reset to HALT, so a start goes straight to DONE.
      step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
      run_done();
      idle(2);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
